// File: rtl/controlador_memoria_instrucoes_pkg.sv
// Shared definitions for the instruction-memory controller: opcodes,
// instruction width, the NOP word and the controller state encoding.
package pacote_izero;

    localparam logic [5:0]  OPCODE_HALT = 6'b111111;
    localparam logic [5:0]  OPCODE_J    = 6'b011111;
    localparam int          INSTR_W     = 32;
    localparam logic [31:0] NOP         = 32'd0;

    typedef enum logic [1:0] {
        CARGA,
        EXEC,
        HALT
    } estado_ctrl_t;

endpackage

// File: rtl/controlador_memoria_instrucoes.sv
// Instruction memory controller.
// Boot-loads the program stream into the instruction memory and then serves
// CPU fetches. It stalls the CPU until the load is done, and it freezes the
// CPU when a halt opcode is fetched.
// Optional feature: CONTROLADOR_CHECKSUM_EN adds an XOR checksum of the
// loaded words. A checksum mismatch sends the controller to HALT.
//
//  state | meaning
//  CARGA | accepting loader words and writing them to memory
//  EXEC  | serving CPU fetches at mem_addr = pc
//  HALT  | halt opcode fetched (or bad checksum); frozen until reset
module controlador_memoria_instrucoes
    import pacote_izero::*;
#(
    parameter int MEM_SIZE = 150,
    parameter int ADDR_W   = 26
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                carga_valid,
    input  logic [INSTR_W-1:0]  carga_dado,
    input  logic                carga_ultimo,
    output logic                carga_ready,
    input  logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [INSTR_W-1:0]  mem_wdata,
    input  logic [INSTR_W-1:0]  mem_rdata,
    output logic [INSTR_W-1:0]  instrucao,
    output logic                cpu_stall,
    output logic                halted,
    output logic                erro_pc,
`ifdef CONTROLADOR_CHECKSUM_EN
    output logic [INSTR_W-1:0]  checksum,
    input  logic [INSTR_W-1:0]  checksum_esperado,
    output logic                erro_checksum,
`endif
    output logic [ADDR_W-1:0]   palavras_carregadas
);

    localparam logic [ADDR_W-1:0] LIM_PC       = ADDR_W'(MEM_SIZE);
    localparam logic [ADDR_W-1:0] ULTIMO_ENDER = ADDR_W'(MEM_SIZE - 1);

    estado_ctrl_t       r_estado;
    estado_ctrl_t       w_estado_prox;
    logic [ADDR_W-1:0]  r_contador;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_mem_we;
    logic [INSTR_W-1:0] r_mem_wdata;
    logic [INSTR_W-1:0] r_instrucao;
    logic               r_halted;
    logic               r_erro_pc;

    logic               w_handshake;
    logic               w_fim_carga;
    logic               w_fetch;
    logic               w_pc_ok;
    logic [INSTR_W-1:0] w_instr_prox;
    logic               w_halt_fetch;
    logic               w_checksum_ruim;

`ifdef CONTROLADOR_CHECKSUM_EN
    logic [INSTR_W-1:0] r_checksum;
    logic               r_erro_checksum;
    logic [INSTR_W-1:0] w_checksum_prox;
`endif

    // Next-state and fetch decode. A fetch is blocked while the final load
    // write is still on the memory port, so the address mux never switches
    // to pc during that write.
    always_comb begin
        w_handshake     = carga_valid && (r_estado == CARGA);
        w_fim_carga     = w_handshake && (carga_ultimo || (r_contador == ULTIMO_ENDER));
        w_fetch         = (r_estado == EXEC) && !r_mem_we;
        w_pc_ok         = (pc < LIM_PC);
        w_instr_prox    = w_pc_ok ? mem_rdata : NOP;
        w_halt_fetch    = w_fetch && (w_instr_prox[31:26] == OPCODE_HALT);
        w_checksum_ruim = 1'b0;
`ifdef CONTROLADOR_CHECKSUM_EN
        w_checksum_prox = r_checksum ^ carga_dado;
        w_checksum_ruim = w_fim_carga && (w_checksum_prox != checksum_esperado);
`endif
        w_estado_prox = r_estado;
        case (r_estado)
            CARGA:   if (w_fim_carga) w_estado_prox = w_checksum_ruim ? HALT : EXEC;
            EXEC:    if (w_halt_fetch) w_estado_prox = HALT;
            HALT:    w_estado_prox = HALT;
            default: w_estado_prox = CARGA;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_estado <= CARGA;
        else       r_estado <= w_estado_prox;
    end

    // Load counter and registered memory write port
    always_ff @(posedge clock) begin
        if (reset) begin
            r_contador  <= '0;
            r_waddr     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_handshake;
            if (w_handshake) begin
                r_waddr     <= r_contador;
                r_mem_wdata <= carga_dado;
                r_contador  <= r_contador + 1'b1;
            end
        end
    end

    // Fetch register plus the sticky error and halt flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instrucao <= NOP;
            r_halted    <= 1'b0;
            r_erro_pc   <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_instrucao <= w_instr_prox;
                if (!w_pc_ok) r_erro_pc <= 1'b1;
            end
            if (w_halt_fetch || w_checksum_ruim) r_halted <= 1'b1;
        end
    end

`ifdef CONTROLADOR_CHECKSUM_EN
    // XOR checksum of accepted words, with a sticky mismatch flag
    always_ff @(posedge clock) begin
        if (reset) begin
            r_checksum      <= '0;
            r_erro_checksum <= 1'b0;
        end else begin
            if (w_handshake)     r_checksum      <= w_checksum_prox;
            if (w_checksum_ruim) r_erro_checksum <= 1'b1;
        end
    end

    assign checksum      = r_checksum;
    assign erro_checksum = r_erro_checksum;
`endif

    assign carga_ready         = (r_estado == CARGA);
    assign cpu_stall           = (r_estado != EXEC) || r_mem_we;
    assign mem_addr            = w_fetch ? pc : r_waddr;
    assign mem_we              = r_mem_we;
    assign mem_wdata           = r_mem_wdata;
    assign instrucao           = r_instrucao;
    assign halted              = r_halted;
    assign erro_pc             = r_erro_pc;
    assign palavras_carregadas = r_contador;

endmodule

// File: tb/tb_controlador_memoria_instrucoes.sv
// Bench for controlador_memoria_instrucoes, with a behavioural instruction
// memory attached. Define CONTROLADOR_CHECKSUM_EN to include the checksum
// sequence.
module tb_controlador_memoria_instrucoes;

    logic        clock = 1'b0;
    logic        reset;
    logic        carga_valid;
    logic [31:0] carga_dado;
    logic        carga_ultimo;
    logic        carga_ready;
    logic [25:0] pc;
    logic [25:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] instrucao;
    logic        cpu_stall;
    logic        halted;
    logic        erro_pc;
    logic [25:0] palavras_carregadas;
`ifdef CONTROLADOR_CHECKSUM_EN
    logic [31:0] checksum;
    logic [31:0] checksum_esperado;
    logic        erro_checksum;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:149];

    always #5 clock = ~clock;

    controlador_memoria_instrucoes #(.MEM_SIZE(150), .ADDR_W(26)) dut (
        .clock               (clock),
        .reset               (reset),
        .carga_valid         (carga_valid),
        .carga_dado          (carga_dado),
        .carga_ultimo        (carga_ultimo),
        .carga_ready         (carga_ready),
        .pc                  (pc),
        .mem_addr            (mem_addr),
        .mem_we              (mem_we),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata),
        .instrucao           (instrucao),
        .cpu_stall           (cpu_stall),
        .halted              (halted),
        .erro_pc             (erro_pc),
`ifdef CONTROLADOR_CHECKSUM_EN
        .checksum            (checksum),
        .checksum_esperado   (checksum_esperado),
        .erro_checksum       (erro_checksum),
`endif
        .palavras_carregadas (palavras_carregadas)
    );

    // Behavioural memory; out-of-range reads return garbage so that the NOP substitution is visible.
    always @(posedge clock)
        if (mem_we && mem_addr < 26'd150) mem[mem_addr[7:0]] <= mem_wdata;
    assign mem_rdata = (mem_addr < 26'd150) ? mem[mem_addr[7:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_chk++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nome, atual, esperado);
        end
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    task automatic aplica_reset();
        reset = 1'b1;
        carga_valid = 1'b0;
        carga_ultimo = 1'b0;
        ciclo();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        valid;
        logic [31:0] dado;
        logic        ultimo;
        logic [25:0] pc;
        logic        exp_we;
        logic [25:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_ready;
        logic        exp_stall;
        logic [25:0] exp_pal;
        logic [31:0] exp_instr;
    } vetor_t;

    vetor_t tab [6];

    initial begin
        int idx, n_wr, n_bad, ultimo_addr;
        logic hs;

        for (int i = 0; i < 150; i++) mem[i] = 32'd0;
        reset = 1'b0; carga_valid = 1'b0; carga_dado = '0; carga_ultimo = 1'b0; pc = '0;
`ifdef CONTROLADOR_CHECKSUM_EN
        checksum_esperado = '0;
`endif
        //              vld  dado            ult  pc     we   addr   wdata          rdy  stl  pal    instr
        tab[0] = '{1'b1, 32'h1111_0001, 1'b0, 26'd0, 1'b1, 26'd0, 32'h1111_0001, 1'b1, 1'b1, 26'd1, 32'd0};
        tab[1] = '{1'b1, 32'h2222_0002, 1'b0, 26'd0, 1'b1, 26'd1, 32'h2222_0002, 1'b1, 1'b1, 26'd2, 32'd0};
        tab[2] = '{1'b1, 32'h3333_0003, 1'b1, 26'd0, 1'b1, 26'd2, 32'h3333_0003, 1'b0, 1'b1, 26'd3, 32'd0};
        tab[3] = '{1'b0, 32'd0,         1'b0, 26'd0, 1'b0, 26'd0, 32'd0,         1'b0, 1'b0, 26'd3, 32'd0};
        tab[4] = '{1'b0, 32'd0,         1'b0, 26'd1, 1'b0, 26'd1, 32'd0,         1'b0, 1'b0, 26'd3, 32'h2222_0002};
        tab[5] = '{1'b0, 32'd0,         1'b0, 26'd2, 1'b0, 26'd2, 32'd0,         1'b0, 1'b0, 26'd3, 32'h3333_0003};

        // Reset state
        aplica_reset();
        chk("rst_ready", carga_ready, 1);
        chk("rst_stall", cpu_stall, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_instr", instrucao, 0);
        chk("rst_halted", halted, 0);
        chk("rst_erro_pc", erro_pc, 0);
        chk("rst_pal", palavras_carregadas, 0);

        // Three-word load followed by fetches, table driven
        for (int v = 0; v < 6; v++) begin
            carga_valid = tab[v].valid; carga_dado = tab[v].dado;
            carga_ultimo = tab[v].ultimo; pc = tab[v].pc;
            ciclo();
            chk($sformatf("t1_we[%0d]", v), mem_we, tab[v].exp_we);
            chk($sformatf("t1_addr[%0d]", v), mem_addr, tab[v].exp_addr);
            if (tab[v].exp_we) chk($sformatf("t1_wdata[%0d]", v), mem_wdata, tab[v].exp_wdata);
            chk($sformatf("t1_ready[%0d]", v), carga_ready, tab[v].exp_ready);
            chk($sformatf("t1_stall[%0d]", v), cpu_stall, tab[v].exp_stall);
            chk($sformatf("t1_pal[%0d]", v), palavras_carregadas, tab[v].exp_pal);
            chk($sformatf("t1_instr[%0d]", v), instrucao, tab[v].exp_instr);
        end

        // Single-word program holding a halt opcode
        aplica_reset();
        pc = 26'd0;
        carga_valid = 1'b1; carga_dado = 32'hFC00_0000; carga_ultimo = 1'b1;
        ciclo();
        carga_valid = 1'b0; carga_ultimo = 1'b0;
        chk("t2_we", mem_we, 1);
        chk("t2_ready", carga_ready, 0);
        chk("t2_stall_write", cpu_stall, 1);
        ciclo();
        chk("t2_stall_exec", cpu_stall, 0);
        chk("t2_halted_pre", halted, 0);
        ciclo();
        chk("t2_instr", instrucao, 32'hFC00_0000);
        chk("t2_halted", halted, 1);
        chk("t2_stall_halt", cpu_stall, 1);
        pc = 26'd1;
        ciclo();
        chk("t2_instr_hold", instrucao, 32'hFC00_0000);
        chk("t2_stall_hold", cpu_stall, 1);

        // 151-word stream with no last marker: truncated at MEM_SIZE
        aplica_reset();
        pc = 26'd0;
        idx = 0; n_wr = 0; n_bad = 0; ultimo_addr = -1;
        for (int c = 0; c < 170; c++) begin
            carga_valid = (idx < 151);
            carga_dado = 32'hA000_0000 + 32'(idx);
            carga_ultimo = 1'b0;
            hs = carga_valid && carga_ready;
            ciclo();
            if (hs) idx++;
            if (mem_we) begin
                if (mem_addr != 26'(n_wr) || mem_wdata != 32'hA000_0000 + 32'(n_wr)) n_bad++;
                ultimo_addr = int'(mem_addr);
                n_wr++;
            end
        end
        carga_valid = 1'b0;
        chk("t3_writes", n_wr, 150);
        chk("t3_last_addr", ultimo_addr, 149);
        chk("t3_accepted", idx, 150);
        chk("t3_seq_errors", n_bad, 0);
        chk("t3_pal", palavras_carregadas, 150);
        chk("t3_ready", carga_ready, 0);
        chk("t3_stall", cpu_stall, 0);

        // Fetch at the last legal address, then one past it
        pc = 26'd149;
        ciclo();
        chk("t4_instr_149", instrucao, 32'hA000_0000 + 32'd149);
        chk("t4_erro_149", erro_pc, 0);
        pc = 26'd150;
        ciclo();
        chk("t4_instr_150", instrucao, 32'd0);
        chk("t4_erro_150", erro_pc, 1);
        pc = 26'd5;
        ciclo();
        chk("t4_instr_5", instrucao, 32'hA000_0005);
        chk("t4_erro_sticky", erro_pc, 1);

        // Reset in the middle of a load
        aplica_reset();
        for (int w = 0; w < 2; w++) begin
            carga_valid = 1'b1; carga_dado = 32'h5500_0000 + 32'(w); carga_ultimo = 1'b0;
            ciclo();
        end
        chk("t5_pal_mid", palavras_carregadas, 2);
        aplica_reset();
        chk("t5_pal_rst", palavras_carregadas, 0);
        chk("t5_stall_rst", cpu_stall, 1);
        carga_valid = 1'b1; carga_dado = 32'h5500_00AA; carga_ultimo = 1'b0;
        ciclo();
        carga_valid = 1'b0;
        chk("t5_we", mem_we, 1);
        chk("t5_addr", mem_addr, 0);
        chk("t5_wdata", mem_wdata, 32'h5500_00AA);
        chk("t5_stall", cpu_stall, 1);
        chk("t5_pal", palavras_carregadas, 1);

`ifdef CONTROLADOR_CHECKSUM_EN
        // Checksum mismatch sends the controller to HALT
        aplica_reset();
        checksum_esperado = 32'h4;
        carga_valid = 1'b1; carga_dado = 32'h1; carga_ultimo = 1'b0;
        ciclo();
        carga_dado = 32'h2; carga_ultimo = 1'b1;
        ciclo();
        carga_valid = 1'b0; carga_ultimo = 1'b0;
        chk("t6_checksum", checksum, 32'h3);
        chk("t6_erro_checksum", erro_checksum, 1);
        chk("t6_halted", halted, 1);
        ciclo();
        chk("t6_stall", cpu_stall, 1);
        // Matching checksum enters EXEC normally
        aplica_reset();
        checksum_esperado = 32'h3;
        carga_valid = 1'b1; carga_dado = 32'h1; carga_ultimo = 1'b0;
        ciclo();
        carga_dado = 32'h2; carga_ultimo = 1'b1;
        ciclo();
        carga_valid = 1'b0; carga_ultimo = 1'b0;
        chk("t6_ok_erro", erro_checksum, 0);
        chk("t6_ok_halted", halted, 0);
        ciclo();
        chk("t6_ok_stall", cpu_stall, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
